// File: rtl/detect_faces_div_pkg.sv
// Shared types and default widths for the detectFaces sequential divider.
package detect_faces_div_pkg;

  localparam int unsigned DefDin0Width = 23;
  localparam int unsigned DefDin1Width = 8;
  localparam int unsigned DefDoutWidth = 23;
  localparam int unsigned CntW         = $clog2(DefDin0Width);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } div_state_e;

endpackage

// File: rtl/detect_faces_udiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, then
// compare/subtract against the divisor.
module detect_faces_udiv_step #(
  parameter int unsigned Width = 8
) (
  input  logic [Width:0]   rem_i,
  input  logic             bit_i,
  input  logic [Width-1:0] divisor_i,
  output logic [Width:0]   rem_o,
  output logic             q_o
);

  localparam int unsigned RW = Width + 1;
  localparam int unsigned SW = Width + 2;

  logic [SW-1:0] shifted;
  logic [SW-1:0] divisor_ext;

  always_comb begin
    shifted     = {rem_i, bit_i};
    divisor_ext = {2'b00, divisor_i};
    q_o         = (shifted >= divisor_ext);
    // Remainder stays below the divisor, so the top bit of the difference is always zero.
    rem_o       = q_o ? RW'(shifted - divisor_ext) : RW'(shifted);
  end

endmodule

// File: rtl/detect_faces_udiv_23ns_8ns_seq.sv
// Iterative unsigned divider with start/done handshake and clock enable;
// one quotient bit per enabled clock, result N+1 enabled cycles after accept.
module detect_faces_udiv_23ns_8ns_seq
  import detect_faces_div_pkg::*;
#(
  parameter int          ID         = 1,
  parameter int unsigned din0_WIDTH = DefDin0Width,
  parameter int unsigned din1_WIDTH = DefDin1Width,
  parameter int unsigned dout_WIDTH = DefDoutWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int unsigned N  = din0_WIDTH;
  localparam int unsigned M  = din1_WIDTH;
  localparam int unsigned CW = $clog2(N);

  if (dout_WIDTH != din0_WIDTH || ID < 0) begin : g_param_check
    $error("dout_WIDTH must equal din0_WIDTH and ID must be non-negative");
  end

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [M-1:0]  divisor_q, divisor_d;
  logic [M:0]    part_q, part_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [M-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [M:0]    step_rem;
  logic          step_q;
  logic          accept;

  detect_faces_udiv_step #(
    .Width(M)
  ) u_step (
    .rem_i    (part_q),
    .bit_i    (shreg_q[N-1]),
    .divisor_i(divisor_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    divisor_d = divisor_q;
    part_d    = part_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ready     = (state_q == StIdle) || (state_q == StDone);
    done      = (state_q == StDone);
    accept    = start && ready;

    unique case (state_q)
      StIdle: ;
      StBusy: begin
        // Quotient bits fill the dividend register from the LSB as dividend bits leave the MSB.
        part_d  = step_rem;
        shreg_d = {shreg_q[N-2:0], step_q};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = StDone;
          if (divisor_q == '0) begin
            quot_d = '1;
            rem_d  = '0;
            dbz_d  = 1'b1;
          end else begin
            quot_d = {shreg_q[N-2:0], step_q};
            rem_d  = step_rem[M-1:0];
            dbz_d  = 1'b0;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d   = StBusy;
      shreg_d   = din0;
      divisor_d = din1;
      part_d    = '0;
      cnt_d     = CW'(N - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      divisor_q <= '0;
      part_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      divisor_q <= divisor_d;
      part_q    <= part_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_detect_faces_udiv_23ns_8ns_seq.sv
// Self-checking bench for the sequential divider against an arithmetic model.
module tb_detect_faces_udiv_23ns_8ns_seq;

  localparam int Lat = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        start;
  logic [22:0] din0;
  logic [7:0]  din1;
  logic        ready;
  logic        done;
  logic [22:0] quot;
  logic [7:0]  rem;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  detect_faces_udiv_23ns_8ns_seq dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .start      (start),
    .din0       (din0),
    .din1       (din1),
    .ready      (ready),
    .done       (done),
    .quot       (quot),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [22:0] a, input logic [7:0] b,
                                output logic [22:0] q, output logic [7:0] r, output logic z);
    if (b == 8'd0) begin
      q = 23'h7FFFFF;
      r = 8'd0;
      z = 1'b1;
    end else begin
      q = a / 23'(b);
      r = 8'(a % 23'(b));
      z = 1'b0;
    end
  endfunction

  // Called at a negedge with ce=1 and ready=1; returns at the negedge after the accept edge.
  task automatic issue(input logic [22:0] a, input logic [7:0] b);
    start = 1'b1;
    din0  = a;
    din1  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    din0  = 23'($urandom);
    din1  = 8'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b0;
    start = 1'b1;
    din0  = 23'd5;
    din1  = 8'd1;
    repeat (3) @(negedge clk);
    tests++;
    if ({ready, done, quot, rem, div_by_zero} !== {1'b1, 1'b0, 23'd0, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset: ready=%b done=%b quot=%0d rem=%0d dbz=%b, want 1 0 0 0 0",
               ready, done, quot, rem, div_by_zero);
    end
    reset = 1'b0;
    start = 1'b0;
    ce    = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [22:0] av[5] = '{23'd1000000, 23'd8388607, 23'd7, 23'd12345, 23'd10};
    logic [7:0]  bv[5] = '{8'd200, 8'd255, 8'd9, 8'd0, 8'd3};
    logic [22:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      issue(av[i], bv[i]);
      wait_done(lat);
      model(av[i], bv[i], eq, er, ez);
      tests++;
      if ({quot, rem, div_by_zero} !== {eq, er, ez} || lat != Lat) begin
        fails++;
        $display("FAIL directed %0d/%0d: quot=%0d rem=%0d dbz=%b lat=%0d, want %0d %0d %b %0d",
                 av[i], bv[i], quot, rem, div_by_zero, lat, eq, er, ez, Lat);
      end
    end
  endtask

  task automatic test_random();
    logic [22:0] a, eq;
    logic [7:0]  b, er;
    logic        ez;
    int          lat;
    for (int i = 0; i < 30; i++) begin
      a = 23'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      @(negedge clk);
      issue(a, b);
      wait_done(lat);
      model(a, b, eq, er, ez);
      tests++;
      if ({quot, rem, div_by_zero} !== {eq, er, ez} || lat != Lat) begin
        fails++;
        $display("FAIL random %0d/%0d: quot=%0d rem=%0d dbz=%b lat=%0d, want %0d %0d %b %0d",
                 a, b, quot, rem, div_by_zero, lat, eq, er, ez, Lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    issue(23'd4000000, 8'd13);
    wait_done(lat);
    tests++;
    if ({ready, quot, rem} !== {1'b1, 23'd307692, 8'd4} || lat != Lat) begin
      fails++;
      $display("FAIL b2b_first: ready=%b quot=%0d rem=%0d lat=%0d, want 1 307692 4 %0d",
               ready, quot, rem, lat, Lat);
    end
    issue(23'd999, 8'd10);
    wait_done(lat);
    tests++;
    if ({quot, rem, div_by_zero} !== {23'd99, 8'd9, 1'b0} || lat != Lat) begin
      fails++;
      $display("FAIL b2b_second: quot=%0d rem=%0d dbz=%b lat=%0d, want 99 9 0 %0d",
               quot, rem, div_by_zero, lat, Lat);
    end
  endtask

  task automatic test_busy_start();
    int cyc;
    @(negedge clk);
    issue(23'd555555, 8'd77);
    cyc = 1;
    repeat (5) begin
      start = 1'b1;
      din0  = 23'd1;
      din1  = 8'd1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if ({quot, rem} !== {23'd7215, 8'd0} || cyc != Lat) begin
      fails++;
      $display("FAIL busy_start: quot=%0d rem=%0d lat=%0d, want 7215 0 %0d", quot, rem, cyc, Lat);
    end
  endtask

  task automatic test_ce_toggle();
    int   en;
    int   guard;
    logic ceval;
    @(negedge clk);
    issue(23'd100, 8'd7);
    en    = 0;
    guard = 0;
    ceval = 1'b0;
    while (done !== 1'b1 && guard < 300) begin
      ce = ceval;
      @(posedge clk);
      if (ce) en++;
      @(negedge clk);
      ceval = ~ceval;
      guard++;
    end
    tests++;
    if ({done, quot, rem} !== {1'b1, 23'd14, 8'd2} || en + 1 != Lat) begin
      fails++;
      $display("FAIL ce_toggle: done=%b quot=%0d rem=%0d enabled=%0d, want 1 14 2 %0d",
               done, quot, rem, en + 1, Lat);
    end
    ce = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL ce_hold_done: done=%b, want 1", done);
    end
    ce = 1'b1;
    @(negedge clk);
    tests++;
    if ({done, ready, quot} !== {1'b0, 1'b1, 23'd14}) begin
      fails++;
      $display("FAIL ce_release: done=%b ready=%b quot=%0d, want 0 1 14", done, ready, quot);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    issue(23'd50000, 8'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({ready, done, quot, rem, div_by_zero} !== {1'b1, 1'b0, 23'd0, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid: ready=%b done=%b quot=%0d rem=%0d dbz=%b, want 1 0 0 0 0",
               ready, done, quot, rem, div_by_zero);
    end
    reset = 1'b0;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_mid_no_done: done cycles=%0d, want 0", seen);
    end
  endtask

  initial begin
    reset = 1'b1;
    ce    = 1'b0;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_busy_start();
    test_ce_toggle();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
